// File: rtl/usb_setup_pkt_assembler.sv
// usb_setup_pkt_assembler
// Endpoint-0 SETUP stage receiver. After a SETUP token, it collects the 8 DATA0
// payload bytes and assembles them into the 64-bit SetupPacket image. It checks
// the length and CRC/PID status, requests the ACK handshake, and holds the
// committed packet for the request decoder until that decoder acknowledges it.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for a SETUP token; payload bytes are ignored
// COLLECT | storing payload bytes 0..7 into the shadow image
// DRAIN   | 8 bytes stored, discarding extra bytes until the packet ends

module usb_setup_pkt_assembler #(
  parameter bit STRICT_LEN = 1'b1
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        setupStart,
  input  logic [7:0]  rxByte,
  input  logic        rxByteValid,
  input  logic        rxLast,
  input  logic        rxPktOk,
  input  logic        rxAbort,
  output logic [63:0] setupPkt,
  output logic        setupValid,
  input  logic        setupAck,
  output logic        reqStd,
  output logic        reqDevToHost,
  output logic        hasDataStage,
  output logic        sendAck,
  output logic        errPulse,
  output logic        overrunPulse
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t      state;
  logic [2:0]  count;
  logic [63:0] shadow;
  logic [63:0] shadow_merged;
  logic        last_byte;
  logic        commit_req;
  logic [63:0] commit_data;

  // Place the incoming byte at its wire-order position. Multi-byte fields
  // arrive low byte first.
  always_comb begin
    shadow_merged = shadow;
    case (count)
      3'd0:    shadow_merged[63:56] = rxByte;
      3'd1:    shadow_merged[55:48] = rxByte;
      3'd2:    shadow_merged[39:32] = rxByte;
      3'd3:    shadow_merged[47:40] = rxByte;
      3'd4:    shadow_merged[23:16] = rxByte;
      3'd5:    shadow_merged[31:24] = rxByte;
      3'd6:    shadow_merged[7:0]   = rxByte;
      default: shadow_merged[15:8]  = rxByte;
    endcase
  end

  // Commit decision. A new SETUP or an abort in the same cycle cancels the
  // packet. The 8th byte can commit only when it carries rxLast.
  always_comb begin
    last_byte   = rxByteValid && rxLast;
    commit_req  = 1'b0;
    commit_data = shadow;
    if (!setupStart && !rxAbort && last_byte && rxPktOk) begin
      if (state == COLLECT && count == 3'd7) begin
        commit_req  = 1'b1;
        commit_data = shadow_merged;
      end else if (state == DRAIN && STRICT_LEN == 1'b0) begin
        commit_req  = 1'b1;
      end
    end
  end

  // Receive FSM, output register and handshake with the downstream decoder.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 3'd0;
      shadow       <= 64'd0;
      setupPkt     <= 64'd0;
      setupValid   <= 1'b0;
      sendAck      <= 1'b0;
      errPulse     <= 1'b0;
      overrunPulse <= 1'b0;
    end else begin
      sendAck      <= 1'b0;
      errPulse     <= 1'b0;
      overrunPulse <= 1'b0;

      if (setupAck && setupValid) begin
        setupValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (setupStart) begin
            state  <= COLLECT;
            count  <= 3'd0;
            shadow <= 64'd0;
          end
        end
        COLLECT, DRAIN: begin
          if (setupStart) begin
            errPulse <= 1'b1;
            state    <= COLLECT;
            count    <= 3'd0;
            shadow   <= 64'd0;
          end else if (rxAbort) begin
            errPulse <= 1'b1;
            state    <= IDLE;
          end else if (rxByteValid) begin
            if (state == COLLECT) begin
              shadow <= shadow_merged;
              count  <= count + 3'd1;
              if (rxLast) begin
                errPulse <= !commit_req;
                state    <= IDLE;
              end else if (count == 3'd7) begin
                state <= DRAIN;
              end
            end else if (rxLast) begin
              errPulse <= !commit_req;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A commit takes priority over a same-cycle setupAck.
      if (commit_req) begin
        setupPkt     <= commit_data;
        setupValid   <= 1'b1;
        sendAck      <= 1'b1;
        overrunPulse <= setupValid && !setupAck;
      end
    end
  end

  assign reqStd       = (setupPkt[62:61] == 2'b00);
  assign reqDevToHost = setupPkt[63];
  assign hasDataStage = |setupPkt[15:0];

endmodule

// File: tb/tb_usb_setup_pkt_assembler.sv
// tb_usb_setup_pkt_assembler
// Runs a strict-length instance (index 0) and a lenient-length instance (index 1)
// from the same receive stream. A packet-level model works out, for each
// packet, whether it commits, which image it yields, and which pulses fire.

module tb_usb_setup_pkt_assembler;

  logic       clk48 = 1'b0;
  logic       rst, setupStart, rxByteValid, rxLast, rxPktOk, rxAbort, setupAck;
  logic [7:0] rxByte;

  logic [63:0] pkt_o [2];
  logic        valid_o [2];
  logic        std_o [2];
  logic        dir_o [2];
  logic        data_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        ovr_o [2];

  int checks = 0;
  int failures = 0;

  int n_ack [2] = '{0, 0};
  int n_err [2] = '{0, 0};
  int n_ovr [2] = '{0, 0};
  int e_ack [2] = '{0, 0};
  int e_err [2] = '{0, 0};
  int e_ovr [2] = '{0, 0};

  logic [63:0] m_pkt [2];
  bit          m_valid [2];
  logic [7:0]  pq [$];

  usb_setup_pkt_assembler #(.STRICT_LEN(1'b1)) dut_s (
    .clk48(clk48), .rst(rst), .setupStart(setupStart), .rxByte(rxByte),
    .rxByteValid(rxByteValid), .rxLast(rxLast), .rxPktOk(rxPktOk), .rxAbort(rxAbort),
    .setupPkt(pkt_o[0]), .setupValid(valid_o[0]), .setupAck(setupAck),
    .reqStd(std_o[0]), .reqDevToHost(dir_o[0]), .hasDataStage(data_o[0]),
    .sendAck(ack_o[0]), .errPulse(err_o[0]), .overrunPulse(ovr_o[0])
  );

  usb_setup_pkt_assembler #(.STRICT_LEN(1'b0)) dut_l (
    .clk48(clk48), .rst(rst), .setupStart(setupStart), .rxByte(rxByte),
    .rxByteValid(rxByteValid), .rxLast(rxLast), .rxPktOk(rxPktOk), .rxAbort(rxAbort),
    .setupPkt(pkt_o[1]), .setupValid(valid_o[1]), .setupAck(setupAck),
    .reqStd(std_o[1]), .reqDevToHost(dir_o[1]), .hasDataStage(data_o[1]),
    .sendAck(ack_o[1]), .errPulse(err_o[1]), .overrunPulse(ovr_o[1])
  );

  always #5 clk48 = ~clk48;

  // Count every pulse so that a stray or stretched pulse shows up in the totals.
  always @(negedge clk48) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < 2; k++) begin
        if (ack_o[k] === 1'b1) n_ack[k]++;
        if (err_o[k] === 1'b1) n_err[k]++;
        if (ovr_o[k] === 1'b1) n_ovr[k]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic do_start();
    setupStart = 1'b1;
    tick();
    setupStart = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b, input bit last, input bit ok);
    rxByteValid = 1'b1;
    rxByte      = b;
    rxLast      = last;
    rxPktOk     = ok;
    tick();
    rxByteValid = 1'b0;
    rxLast      = 1'b0;
    rxPktOk     = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 64'(valid_o[k]), 64'(m_valid[k]));
      chk($sformatf("%s.pkt%0d", tag, k), pkt_o[k], m_pkt[k]);
      chk($sformatf("%s.std%0d", tag, k), 64'(std_o[k]), 64'(m_pkt[k][62:61] == 2'b00));
      chk($sformatf("%s.dir%0d", tag, k), 64'(dir_o[k]), 64'(m_pkt[k][63]));
      chk($sformatf("%s.data%0d", tag, k), 64'(data_o[k]), 64'(m_pkt[k][15:0] != 16'd0));
    end
  endtask

  task automatic ack_now(input string tag);
    setupAck = 1'b1;
    tick();
    setupAck = 1'b0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    check_state(tag);
  endtask

  // Sends SETUP plus the bytes in pq and checks the cycle after the packet ends.
  task automatic run_packet(input string tag, input bit ok, input int abort_at,
                            input bit ack_commit, input bit gaps);
    int          n;
    bit          aborted;
    bit          c [2];
    bit          ov [2];
    logic [63:0] e;
    n       = pq.size();
    aborted = 1'b0;
    do_start();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rxLast = 1'($urandom);
        rxByte = 8'($urandom);
        tick();
        rxLast = 1'b0;
      end
      if (i == abort_at) begin
        rxAbort = 1'b1;
        tick();
        rxAbort = 1'b0;
        aborted = 1'b1;
        break;
      end
      setupAck = ack_commit && (i == n - 1);
      do_byte(pq[i], i == n - 1, ok);
      setupAck = 1'b0;
    end
    if (n >= 8) e = {pq[0], pq[1], pq[3], pq[2], pq[5], pq[4], pq[7], pq[6]};
    else        e = 64'd0;
    c[0] = !aborted && ok && (n == 8);
    c[1] = !aborted && ok && (n >= 8);
    for (int k = 0; k < 2; k++) begin
      ov[k] = c[k] && m_valid[k] && !ack_commit;
      if (c[k]) begin
        m_pkt[k]   = e;
        m_valid[k] = 1'b1;
        e_ack[k]++;
        if (ov[k]) e_ovr[k]++;
      end else begin
        e_err[k]++;
        if (!aborted && ack_commit) m_valid[k] = 1'b0;
      end
      chk($sformatf("%s.sendAck%0d", tag, k), 64'(ack_o[k]), 64'(c[k]));
      chk($sformatf("%s.errPulse%0d", tag, k), 64'(err_o[k]), 64'(!c[k]));
      chk($sformatf("%s.overrun%0d", tag, k), 64'(ovr_o[k]), 64'(ov[k]));
    end
    check_state(tag);
    tick();
  endtask

  initial begin
    int len;
    int ab;
    rst = 1'b1; setupStart = 1'b0; rxByte = 8'd0; rxByteValid = 1'b0;
    rxLast = 1'b0; rxPktOk = 1'b0; rxAbort = 1'b0; setupAck = 1'b0;
    m_pkt[0] = 64'd0; m_pkt[1] = 64'd0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset.sendAck%0d", k), 64'(ack_o[k]), 64'd0);
      chk($sformatf("reset.errPulse%0d", k), 64'(err_o[k]), 64'd0);
      chk($sformatf("reset.overrun%0d", k), 64'(ovr_o[k]), 64'd0);
    end
    check_state("reset");

    // Payload bytes with no SETUP token in front of them must be ignored.
    repeat (3) do_byte(8'hA5, 1'b1, 1'b1);
    check_state("idle_bytes");

    pq = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
    run_packet("get_desc", 1'b1, -1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("get_desc.image%0d", k), pkt_o[k], 64'h8006_0100_0000_0012);
      chk($sformatf("get_desc.flags%0d", k), {61'd0, std_o[k], dir_o[k], data_o[k]}, 64'd7);
    end
    ack_now("get_desc_ack");

    pq = '{8'h00, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_packet("set_addr", 1'b1, -1, 1'b0, 1'b0);
    chk("set_addr.wValue", 64'(pkt_o[0][47:32]), 64'h0007);
    chk("set_addr.hasData", 64'(data_o[0]), 64'd0);
    ack_now("set_addr_ack");
    ack_now("ack_when_empty");

    // Leave a packet pending so that the error cases below must preserve it.
    pq = '{8'h21, 8'h09, 8'h00, 8'h02, 8'h01, 8'h00, 8'h04, 8'h00};
    run_packet("pending", 1'b1, -1, 1'b0, 1'b0);

    pq = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00};
    run_packet("short6", 1'b1, -1, 1'b0, 1'b0);
    pq = '{8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'h09, 8'h00};
    run_packet("bad_crc", 1'b0, -1, 1'b0, 1'b0);
    run_packet("abort3", 1'b1, 3, 1'b0, 1'b0);
    pq = '{8'hC0, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hEE};
    run_packet("len9", 1'b1, -1, 1'b0, 1'b0);

    pq = '{8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_packet("b2b_first", 1'b1, -1, 1'b0, 1'b0);
    pq = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    run_packet("b2b_second", 1'b1, -1, 1'b0, 1'b0);
    pq = '{8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_packet("b2b_ack_commit", 1'b1, -1, 1'b1, 1'b0);

    // A second SETUP in mid-packet discards the partial packet with an error.
    do_start();
    for (int i = 0; i < 3; i++) do_byte(8'h5A, 1'b0, 1'b0);
    e_err[0]++; e_err[1]++;
    pq = '{8'h01, 8'h0B, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet("restart", 1'b1, -1, 1'b0, 1'b0);

    // Reset in mid-packet: the rest of that packet is silently dropped.
    do_start();
    for (int i = 0; i < 4; i++) do_byte(8'h80 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pkt[0] = 64'd0; m_pkt[1] = 64'd0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    for (int i = 4; i < 8; i++) do_byte(8'h10 + 8'(i), i == 7, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_mid.sendAck%0d", k), 64'(ack_o[k]), 64'd0);
      chk($sformatf("rst_mid.errPulse%0d", k), 64'(err_o[k]), 64'd0);
    end
    check_state("rst_mid");
    tick();
    pq = '{8'h80, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    run_packet("after_rst", 1'b1, -1, 1'b0, 1'b0);

    for (int p = 0; p < 40; p++) begin
      pq.delete();
      len = ($urandom_range(0, 9) < 6) ? 8 : int'($urandom_range(5, 10));
      for (int i = 0; i < len; i++) pq.push_back(8'($urandom));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_packet($sformatf("rnd%0d", p), $urandom_range(0, 4) != 0, ab,
                 1'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0) ack_now($sformatf("rnd%0d_ack", p));
      if ($urandom_range(0, 3) == 0) do_byte(8'($urandom), 1'b1, 1'b1);
    end

    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("total.sendAck%0d", k), 64'(n_ack[k]), 64'(e_ack[k]));
      chk($sformatf("total.errPulse%0d", k), 64'(n_err[k]), 64'(e_err[k]));
      chk($sformatf("total.overrun%0d", k), 64'(n_ovr[k]), 64'(e_ovr[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
